// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: handshake and operand/result bundle for the sequential mul/div unit.
//   master: issues operations (in_valid, SrcA, SrcB, Operation, flush, out_ready)
//           and observes in_ready, out_valid, ALUResult, busy.
//   slave : the mul/div unit itself.
interface alu_muldiv_seq_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    ALUResult;
  logic                     busy;

  modport master (
    output in_valid, SrcA, SrcB, Operation, flush, out_ready,
    input  in_ready, out_valid, ALUResult, busy
  );

  modport slave (
    input  in_valid, SrcA, SrcB, Operation, flush, out_ready,
    output in_ready, out_valid, ALUResult, busy
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle RV32M multiply/divide unit, radix-2 (one bit per cycle).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - alu_muldiv_seq_if.slave: in_valid/in_ready, SrcA, SrcB, Operation, flush,
//           out_valid/out_ready, ALUResult (registered), busy (CALC or DONE)
// Opcodes: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 1xxx -> 0.
// Optional macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a full-width
// multiplier; when undefined every multiply is iterative and no multiplier is inferred.
module alu_muldiv_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic            clk,
  input logic            reset,
  alu_muldiv_seq_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state_q;
  logic [2:0]    op_q;
  logic          neg_q;     // result sign recorded at accept
  logic [W-1:0]  b_q;       // |multiplicand| or |divisor|
  logic [W-1:0]  hi_q;      // product high half / partial remainder
  logic [W-1:0]  lo_q;      // multiplier bits / dividend bits, becomes product low / quotient
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  result_q;

  // ---------------- operand decode (IDLE) ----------------
  logic [OPCODE_LENGTH-1:0] op_in;
  logic a_signed, b_signed, sa, sb, in_neg;
  logic invalid, div_zero, ovf;
  logic [W-1:0] mag_a, mag_b;

  assign op_in    = bus.Operation;
  assign invalid  = |op_in[OPCODE_LENGTH-1:3];
  assign a_signed = (op_in[2:0] == 3'b001) || (op_in[2:0] == 3'b010) ||
                    (op_in[2:0] == 3'b100) || (op_in[2:0] == 3'b110);
  assign b_signed = (op_in[2:0] == 3'b001) || (op_in[2:0] == 3'b100) ||
                    (op_in[2:0] == 3'b110);
  assign sa       = a_signed & bus.SrcA[W-1];
  assign sb       = b_signed & bus.SrcB[W-1];
  assign mag_a    = sa ? -bus.SrcA : bus.SrcA;
  assign mag_b    = sb ? -bus.SrcB : bus.SrcB;
  assign div_zero = op_in[2] && (bus.SrcB == '0);
  assign ovf      = op_in[2] && !op_in[0] && (bus.SrcA == MOST_NEG) && (&bus.SrcB);

  // Product/quotient follows both signs; MULHSU and remainders follow the first operand.
  always_comb begin
    in_neg = 1'b0;
    case (op_in[2:0])
      3'b001, 3'b100: in_neg = sa ^ sb;
      3'b010, 3'b110: in_neg = sa;
      default:        in_neg = 1'b0;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] fm_full, fm_fix;
  assign fm_full = mag_a * mag_b;
  assign fm_fix  = in_neg ? -fm_full : fm_full;
`endif

  // Cases finished without iterating: result is loaded on the accepting edge.
  logic         fast_hit;
  logic [W-1:0] fast_res;
  always_comb begin
    fast_hit = 1'b1;
    fast_res = '0;
    if (invalid)       fast_res = '0;
    else if (div_zero) fast_res = op_in[1] ? bus.SrcA : '1;
    else if (ovf)      fast_res = op_in[1] ? '0 : MOST_NEG;
`ifdef MULDIV_FAST_MUL_EN
    else if (!op_in[2]) fast_res = (op_in[1:0] == 2'b00) ? fm_fix[W-1:0] : fm_fix[2*W-1:W];
`endif
    else               fast_hit = 1'b0;
  end

  // ---------------- iterative step (CALC) ----------------
  logic [W:0]   mul_sum, div_diff;
  logic [W-1:0] step_hi, step_lo;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_diff = {hi_q, lo_q[W-1]} - {1'b0, b_q};

  always_comb begin
    if (op_q[2]) begin
      // Restoring divide: keep the shifted remainder when the trial subtract borrows.
      step_hi = div_diff[W] ? {hi_q[W-2:0], lo_q[W-1]} : div_diff[W-1:0];
      step_lo = {lo_q[W-2:0], ~div_diff[W]};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  // Sign fix-up and half selection applied to the value produced by the last step.
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quot_fix, rem_fix, final_res;
  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = neg_q ? -step_lo : step_lo;
  assign rem_fix  = neg_q ? -step_hi : step_hi;

  always_comb begin
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod_fix[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*W-1:W];
      3'b100, 3'b101:         final_res = quot_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= op_in[2:0];
            neg_q <= in_neg;
            b_q   <= mag_b;
            lo_q  <= mag_a;
            hi_q  <= '0;
            cnt_q <= CW'(W - 1);
            if (fast_hit) begin
              result_q <= fast_res;
              state_q  <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= final_res;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.ALUResult = result_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  alu_muldiv_seq_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) bus ();

  alu_muldiv_seq #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    if (op[3]) return 32'h0;
    case (op[2:0])
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb;                 return p[63:32]; end
      3'd2: begin p = sa * ub;                 return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from presenting in_valid until out_valid is seen.
  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[3]) return 1;
    if (op[2] && b == 0) return 1;
    if (op[2] && !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp;
    int          cyc;
    exp = ref_result(op, a, b);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.Operation = op;
    check("in_ready idle", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.SrcA      = $urandom;
    bus.SrcB      = $urandom;
    bus.Operation = 4'($urandom);
    cyc = 1;
    while (!bus.out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("latency op%0h", op), 32'(cyc), 32'(ref_latency(op, a, b)));
    check($sformatf("result op%0h %h %h", op, a, b), bus.ALUResult, exp);
    check("in_ready done", {31'b0, bus.in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold out_valid", {31'b0, bus.out_valid}, 32'd1);
      check("hold result", bus.ALUResult, exp);
      check("hold in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("after accept out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("after accept in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("result retained", bus.ALUResult, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          seen;
    logic [3:0]  rop;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.Operation = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset result", bus.ALUResult, 32'd0);
    reset = 1'b0;

    run_op(4'd0, 32'd3, 32'd4, 0);

    // Reset during an iterative DIVU.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.SrcA = 32'd1000; bus.SrcB = 32'd7; bus.Operation = 4'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid calc busy", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("async reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("async reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("async reset result", bus.ALUResult, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(4'd0, 32'd3, 32'd4, 0);

    // Multiplies.
    run_op(4'd0, 32'hFFFFFFFF, 32'h2, 0);
    run_op(4'd1, 32'hFFFFFFFF, 32'h2, 0);
    run_op(4'd3, 32'hFFFFFFFF, 32'h2, 0);
    run_op(4'd2, 32'hFFFFFFFF, 32'h2, 0);
    // Divides.
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, 0);
    run_op(4'd6, 32'hFFFFFFF9, 32'd2, 0);
    run_op(4'd5, 32'd100, 32'd7, 0);
    run_op(4'd7, 32'd100, 32'd7, 0);
    // Divide by zero and signed overflow.
    run_op(4'd4, 32'h12345678, 32'd0, 0);
    run_op(4'd7, 32'h12345678, 32'd0, 0);
    run_op(4'd4, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(4'd6, 32'h80000000, 32'hFFFFFFFF, 0);
    // Backpressure in DONE.
    run_op(4'd5, 32'd100, 32'd7, 5);

    // Flush during CALC keeps the previous result and never raises out_valid.
    run_op(4'd0, 32'd5, 32'd6, 0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.SrcA = 32'd1000; bus.SrcB = 32'd3; bus.Operation = 4'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("flush busy", {31'b0, bus.busy}, 32'd0);
    check("flush result kept", bus.ALUResult, 32'd30);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("flush no out_valid", 32'(seen), 32'd0);

    // flush together with in_valid in IDLE must not accept.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.Operation = 4'd5;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush blocks accept", {31'b0, bus.busy}, 32'd0);

    // Invalid opcode.
    run_op(4'b1010, 32'h1234, 32'h5678, 0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      run_op(rop, pick(), pick(), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
